gmii_tx_framer: RTL

GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

---
 rtl/gmii_tx_framer_if.sv | 11 +
 rtl/gmii_tx_framer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/gmii_tx_framer_if.sv
// Byte-stream handshake feeding the GMII transmit framer.
// The master drives payload bytes and the slave answers with s_ready.
interface gmii_tx_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_last, input  s_ready);
    modport slave  (input  s_data, input  s_valid, input  s_last, output s_ready);
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload with zero pad to MIN_LEN, CRC-32 FCS,
// inter-frame gap, and single-cycle tx_er abort with discard on source underrun.
module gmii_tx_framer #(
    parameter int IFG     = 12,
    parameter int MIN_LEN = 60
) (
    input  logic             clk,
    input  logic             reset,
    gmii_tx_framer_if.slave  s_if,
    output logic [7:0]       gmii_txd,
    output logic             gmii_tx_en,
    output logic             gmii_tx_er,
    output logic             busy,
    output logic [15:0]      frame_count,
    output logic [15:0]      underrun_count
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_PREAMBLE, ST_SFD, ST_PAYLOAD, ST_PAD, ST_FCS, ST_IFG, ST_DISCARD
    } state_t;

    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
    localparam logic [15:0] IFG_LAST  = 16'(IFG - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] r_sub;
    logic [15:0] w_cnt_inc;
    logic [31:0] r_crc;
    logic [31:0] w_fcs;
    logic        w_accept;
    logic [7:0]  w_txd;
    logic        w_tx_en;
    logic        w_tx_er;

    // Reflected CRC-32 (poly 0x04C11DB7 bit-reversed), one byte LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int b = 0; b < 8; b++)
            c = (c[0] ^ data[b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    assign w_cnt_inc     = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_fcs         = ~r_crc;
    assign s_if.s_ready  = (r_state == ST_PAYLOAD) || (r_state == ST_DISCARD);
    assign w_accept      = s_if.s_valid & s_if.s_ready;
    assign busy          = (r_state != ST_IDLE);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: default first so no path through the case leaves a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (s_if.s_valid) w_state_nxt = ST_PREAMBLE;
            ST_PREAMBLE: if (r_sub == 16'd5) w_state_nxt = ST_SFD;
            ST_SFD:      w_state_nxt = ST_PAYLOAD;
            ST_PAYLOAD: begin
                if (!s_if.s_valid)
                    w_state_nxt = ST_DISCARD;
                else if (s_if.s_last)
                    w_state_nxt = (w_cnt_inc < MIN_LEN_W) ? ST_PAD : ST_FCS;
            end
            ST_PAD:      if (w_cnt_inc >= MIN_LEN_W) w_state_nxt = ST_FCS;
            ST_FCS:      if (r_sub == 16'd3) w_state_nxt = ST_IFG;
            ST_IFG:      if (r_sub == IFG_LAST) w_state_nxt = ST_IDLE;
            ST_DISCARD:  if (s_if.s_valid && s_if.s_last) w_state_nxt = ST_IFG;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // GMII outputs are registered, so each state decides what appears one cycle later.
    always_comb begin
        w_txd   = 8'h00;
        w_tx_en = 1'b0;
        w_tx_er = 1'b0;
        case (r_state)
            ST_IDLE: if (s_if.s_valid) begin
                w_tx_en = 1'b1;
                w_txd   = 8'h55;
            end
            ST_PREAMBLE: begin
                w_tx_en = 1'b1;
                w_txd   = 8'h55;
            end
            ST_SFD: begin
                w_tx_en = 1'b1;
                w_txd   = 8'hD5;
            end
            ST_PAYLOAD: begin
                w_tx_en = 1'b1;
                if (s_if.s_valid) w_txd   = s_if.s_data;
                else              w_tx_er = 1'b1;
            end
            ST_PAD:  w_tx_en = 1'b1;
            ST_FCS: begin
                w_tx_en = 1'b1;
                w_txd   = w_fcs[{r_sub[1:0], 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gmii_txd       <= 8'h00;
            gmii_tx_en     <= 1'b0;
            gmii_tx_er     <= 1'b0;
            r_sub          <= 16'd0;
            r_cnt          <= 16'd0;
            r_crc          <= 32'hFFFF_FFFF;
            frame_count    <= 16'd0;
            underrun_count <= 16'd0;
        end else begin
            gmii_txd   <= w_txd;
            gmii_tx_en <= w_tx_en;
            gmii_tx_er <= w_tx_er;
            r_sub      <= (w_state_nxt != r_state) ? 16'd0 : r_sub + 16'd1;
            case (r_state)
                ST_SFD: begin
                    r_crc <= 32'hFFFF_FFFF;
                    r_cnt <= 16'd0;
                end
                ST_PAYLOAD: if (w_accept) begin
                    r_crc <= crc32_byte(r_crc, s_if.s_data);
                    r_cnt <= w_cnt_inc;
                end
                ST_PAD: begin
                    r_crc <= crc32_byte(r_crc, 8'h00);
                    r_cnt <= w_cnt_inc;
                end
                default: ;
            endcase
            if (r_state == ST_FCS && r_sub == 16'd3)
                frame_count <= frame_count + 16'd1;
            if (r_state == ST_PAYLOAD && !s_if.s_valid)
                underrun_count <= underrun_count + 16'd1;
        end
    end
endmodule
